// File: rtl/multi_debounce_pkg.sv
// ============================================================================
// Module   : multi_debounce_pkg
// Brief    : Shared state encoding and default constants for multi_debounce.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } db_state_t;

    localparam int c_TICK_W_DEFAULT       = 19;
    localparam int c_STABLE_TICKS_DEFAULT = 3;
    localparam int c_CNT_W                = 4;

endpackage

`default_nettype wire

// File: rtl/multi_debounce_db_channel.sv
// ============================================================================
// Module   : db_channel
// Brief    : One debounce channel: optional 2-flop synchroniser (DEBOUNCE_SYNC_EN),
//            four-state stability FSM, tick counter and registered edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module db_channel
    import multi_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = c_STABLE_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_TICKS - 1);

    logic               w_sw;
    db_state_t          r_state;
    db_state_t          w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_rise;
    logic               r_fall;
    logic               w_rise_nxt;
    logic               w_fall_nxt;

`ifdef DEBOUNCE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sw = r_sync2;
`else
    assign w_sw = sw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ZERO;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // An input change always wins over a coincident tick, so the tick is not counted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            ZERO: begin
                if (w_sw) begin
                    w_state_nxt = WAIT1;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT1: begin
                if (!w_sw) begin
                    w_state_nxt = ZERO;
                end else if (tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = ONE;
                        w_cnt_nxt   = '0;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ONE: begin
                if (!w_sw) begin
                    w_state_nxt = WAIT0;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT0: begin
                if (w_sw) begin
                    w_state_nxt = ONE;
                end else if (tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = ZERO;
                        w_cnt_nxt   = '0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ZERO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign db   = (r_state == ONE) || (r_state == WAIT0);
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/multi_debounce.sv
// ============================================================================
// Module   : multi_debounce
// Brief    : N_CH independent switch debouncers sharing one free-running sample
//            tick. Define DEBOUNCE_SYNC_EN to add a 2-flop input synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_debounce
    import multi_debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_W       = c_TICK_W_DEFAULT,
    parameter int STABLE_TICKS = c_STABLE_TICKS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            tick
);

    logic [TICK_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= r_q + TICK_W'(1);
        end
    end

    assign tick = (r_q == '0);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            db_channel #(
                .STABLE_TICKS (STABLE_TICKS)
            ) u_ch (
                .clk   (clk),
                .rst_n (rst_n),
                .tick  (tick),
                .sw    (sw[gi]),
                .db    (db[gi]),
                .rise  (rise[gi]),
                .fall  (fall[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire
